// File: rtl/sub_chunk_sequencer.sv
// sub_chunk_sequencer
//   Multi-cycle subtractor D = X - Y - b_in. One CHUNK-bit borrow slice is
//   reused once per cycle, LSB slice first, with the borrow carried in a
//   register between cycles. It has a valid/ready operand side and a
//   valid/ready result side.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for operands; in_ready high
//   RUN    | one CHUNK-bit slice per cycle, idx = 0 .. N-1
//   DONE   | result valid and held until out_ready
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   operand request valid
//   in_ready   operands accepted this cycle (combinational, IDLE only)
//   in_x       minuend X
//   in_y       subtrahend Y
//   in_bin     borrow-in to the LSB slice
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_d      difference D (unsigned modulo 2^WIDTH)
//   out_bout   borrow-out of the MSB slice (1 => X < Y + b_in)
//   busy       high whenever the FSM is not in IDLE
module sub_chunk_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_bout,
    output logic             busy
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("sub_chunk_sequencer: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             borrow;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;

    logic [CHUNK-1:0] x_slice;
    logic [CHUNK-1:0] y_slice;
    logic [CHUNK:0]   slice_diff;

    assign in_ready = rst_n & (state == S_IDLE);

    // Shared slice: the extra top bit of the (CHUNK+1)-bit difference goes
    // to 1 exactly when the slice underflows, i.e. it is the ripple borrow.
    assign x_slice    = x_q[idx*CHUNK +: CHUNK];
    assign y_slice    = y_q[idx*CHUNK +: CHUNK];
    assign slice_diff = {1'b0, x_slice} - {1'b0, y_slice} - {{CHUNK{1'b0}}, borrow};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            borrow    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            out_valid <= 1'b0;
            out_d     <= '0;
            out_bout  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q    <= in_x;
                        y_q    <= in_y;
                        borrow <= in_bin;
                        out_d  <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    out_d[idx*CHUNK +: CHUNK] <= slice_diff[CHUNK-1:0];
                    borrow                    <= slice_diff[CHUNK];
                    idx                       <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        out_bout  <= slice_diff[CHUNK];
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_chunk_sequencer.sv
module tb_sub_chunk_sequencer;

    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;
    // N RUN cycles, one DONE cycle, one IDLE cycle before the next accept edge.
    localparam int ACC_GAP = N + 2;

    typedef struct {
        logic [31:0] d;
        logic        bout;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        bin;
        logic [31:0] d;
        logic        bout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic        out_bout;
    logic        busy;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    sub_chunk_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_bout  (out_bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic b);
        logic [32:0] t;
        exp_t        r;
        t      = {1'b0, x} - {1'b0, y} - {32'd0, b};
        r.d    = t[31:0];
        r.bout = t[32];
        return r;
    endfunction

    // Result monitor: every completed output handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got d=%0h with nothing pending, expected no output", out_d);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_d", {32'd0, out_d}, {32'd0, mon_e.d});
                chk("out_bout", {63'd0, out_bout}, {63'd0, mon_e.bout});
            end
        end
    end

    // Present operands, wait for acceptance, then scramble the inputs so a
    // design that keeps reading in_x/in_y after acceptance is caught.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic b,
                        input logic [31:0] ed, input logic eb, input bit push);
        bit   ok;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_bin   = b;
        ok       = 1'b0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) begin
                e.d    = ed;
                e.bout = eb;
                sb_q.push_back(e);
            end
            #1;
            in_valid = 1'b0;
            in_x     = ~x;
            in_y     = ~y;
            in_bin   = ~b;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 60 && sb_q.size() != 0; g++) @(negedge clk);
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    vec_t tbl[8];
    int   lat;
    int   acc_cyc[$];
    exp_t ea;
    exp_t eb;

    initial begin
        tbl[0] = '{x: 32'h0000_0005, y: 32'h0000_0003, bin: 1'b0, d: 32'h0000_0002, bout: 1'b0};
        tbl[1] = '{x: 32'h0000_0000, y: 32'h0000_0001, bin: 1'b0, d: 32'hFFFF_FFFF, bout: 1'b1};
        tbl[2] = '{x: 32'h8000_0000, y: 32'h0000_0001, bin: 1'b1, d: 32'h7FFF_FFFE, bout: 1'b0};
        tbl[3] = '{x: 32'h1234_ABCD, y: 32'h1234_ABCD, bin: 1'b1, d: 32'hFFFF_FFFF, bout: 1'b1};
        tbl[4] = '{x: 32'hFFFF_FFFF, y: 32'h0000_0000, bin: 1'b1, d: 32'hFFFF_FFFE, bout: 1'b0};
        tbl[5] = '{x: 32'h0000_0000, y: 32'h0000_0000, bin: 1'b1, d: 32'hFFFF_FFFF, bout: 1'b1};
        tbl[6] = '{x: 32'h0000_0000, y: 32'hFFFF_FFFF, bin: 1'b0, d: 32'h0000_0001, bout: 1'b1};
        tbl[7] = '{x: 32'h0F0F_0F0F, y: 32'hF0F0_F0F0, bin: 1'b0, d: 32'h1E1E_1E1F, bout: 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_bin    = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_d", {32'd0, out_d}, 64'd0);
        chk("rst_out_bout", {63'd0, out_bout}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors with latency check.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].bin, tbl[i].d, tbl[i].bout, 1'b1);
            wait_valid(lat);
            chk($sformatf("latency[%0d]", i), 64'(lat), 64'(N));
        end
        wait_drain();

        // Backpressure: result held, new request ignored until released.
        out_ready = 1'b0;
        ea = model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        eb = model(32'h0000_0100, 32'h0000_0200, 1'b0);
        send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, ea.d, ea.bout, 1'b1);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'(N));
        in_valid = 1'b1;
        in_x     = 32'h0000_0100;
        in_y     = 32'h0000_0200;
        in_bin   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_d", {32'd0, out_d}, {32'd0, ea.d});
            chk("bp_out_bout", {63'd0, out_bout}, {63'd0, ea.bout});
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_idle_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        sb_q.push_back(eb);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accept_busy", {63'd0, busy}, 64'd1);
        wait_drain();

        // Reset in the middle of RUN (idx == 3): operation discarded.
        send(32'hFFFF_FFFF, 32'h1111_1111, 1'b0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_d", {32'd0, out_d}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (N + 2) @(negedge clk);
        chk("mid_rst_no_output", {63'd0, out_valid}, 64'd0);
        send(32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b1);
        wait_drain();

        // Back-to-back with in_valid and out_ready held high.
        begin
            int   k;
            int   guard;
            logic [31:0] bx [4];
            logic [31:0] by [4];
            logic        bb [4];
            for (int i = 0; i < 4; i++) begin
                bx[i] = $urandom;
                by[i] = $urandom;
                bb[i] = 1'($urandom_range(0, 1));
            end
            k     = 0;
            guard = 0;
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_x     = bx[0];
            in_y     = by[0];
            in_bin   = bb[0];
            while (k < 4 && guard < 200) begin
                @(negedge clk);
                guard++;
                if (in_ready) begin
                    @(posedge clk);
                    sb_q.push_back(model(bx[k], by[k], bb[k]));
                    acc_cyc.push_back(cyc);
                    #1;
                    k++;
                    if (k < 4) begin
                        in_x   = bx[k];
                        in_y   = by[k];
                        in_bin = bb[k];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            in_valid = 1'b0;
            chk("b2b_accepts", 64'(k), 64'd4);
            for (int i = 1; i < acc_cyc.size(); i++)
                chk($sformatf("b2b_gap[%0d]", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(ACC_GAP));
            wait_drain();
        end

        // Random sweep against the flat golden model.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] rx;
            logic [31:0] ry;
            logic        rb;
            exp_t        re;
            rx = $urandom;
            ry = (i % 8 == 0) ? rx : $urandom;
            rb = 1'($urandom_range(0, 1));
            re = model(rx, ry, rb);
            send(rx, ry, rb, re.d, re.bout, 1'b1);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
